// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        WAIT_IDLE,
        FAIL
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_START_TO = 2'd1;
    localparam logic [1:0] ERR_XFER_TO  = 2'd2;
    localparam logic [1:0] ERR_NACK     = 2'd3;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for the PS/2 clock pin.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // Accept a new level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            level  <= 1'b1;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin};
            fall   <= 1'b0;
            if (sync_q[1] != level) begin
                if (cnt_q == CW'(FILTER_LEN - 1)) begin
                    level <= sync_q[1];
                    cnt_q <= '0;
                    // Old level high means the accepted level is low.
                    fall  <= level;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pin enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = 6500,
    parameter int START_TIMEOUT_CYCLES = 975000,
    parameter int XFER_TIMEOUT_CYCLES  = 130000,
    parameter int FILTER_LEN           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int TW = $clog2(START_TIMEOUT_CYCLES + 1);

    localparam logic [TW-1:0] INH_DATA   = TW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [TW-1:0] cnt;
    logic [3:0]    bit_n;
    logic [7:0]    data_q;
    logic          parity_q;
    logic [1:0]    data_sync_q;
    logic          clk_level;
    logic          clk_fall;
    logic [3:0]    next_n;
    logic          shift_bit;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .pin  (ps2_clk_in),
        .level(clk_level),
        .fall (clk_fall)
    );

    // Data pin is only resynchronized; it is sampled on filtered clock edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_sync_q <= 2'b11;
        end else begin
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    // Bit to present after the next falling edge: data[n-1] equals data[bit_n].
    always_comb begin
        next_n = bit_n + 4'd1;
        if (next_n == 4'd9) begin
            shift_bit = parity_q;
        end else if (next_n == 4'd10) begin
            shift_bit = 1'b1;
        end else begin
            shift_bit = data_q[bit_n[2:0]];
        end
    end

    // Request-to-send sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_n       <= '0;
            data_q      <= '0;
            parity_q    <= 1'b0;
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            err_code    <= ERR_NONE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_ready    <= 1'b1;
                    cnt         <= '0;
                    if (tx_start) begin
                        data_q     <= tx_data;
                        parity_q   <= odd_parity(tx_data);
                        err_code   <= ERR_NONE;
                        tx_ready   <= 1'b0;
                        ps2_clk_oe <= 1'b1;
                        bit_n      <= '0;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    cnt <= cnt + 1'b1;
                    // Start bit goes low while the clock is still held.
                    if (cnt == INH_DATA) ps2_data_oe <= 1'b1;
                    if (cnt == INH_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        cnt        <= '0;
                        state      <= START;
                    end
                end
                START: begin
                    cnt <= cnt + 1'b1;
                    if (clk_fall) begin
                        ps2_data_oe <= ~data_q[0];
                        bit_n       <= 4'd1;
                        cnt         <= '0;
                        state       <= SHIFT;
                    end else if (cnt == START_LAST) begin
                        err_code    <= ERR_START_TO;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= FAIL;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == XFER_LAST) begin
                        err_code    <= ERR_XFER_TO;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= FAIL;
                    end else if (clk_fall) begin
                        bit_n       <= next_n;
                        ps2_data_oe <= ~shift_bit;
                        if (next_n == 4'd10) state <= ACK;
                    end
                end
                ACK: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == XFER_LAST) begin
                        err_code    <= ERR_XFER_TO;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= FAIL;
                    end else if (clk_fall) begin
                        ps2_data_oe <= 1'b0;
                        if (!data_sync_q[1]) begin
                            state <= WAIT_IDLE;
                        end else begin
                            err_code <= ERR_NACK;
                            state    <= FAIL;
                        end
                    end
                end
                WAIT_IDLE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == XFER_LAST) begin
                        err_code    <= ERR_XFER_TO;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= FAIL;
                    end else if (clk_level && data_sync_q[1]) begin
                        tx_done  <= 1'b1;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                FAIL: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_done     <= 1'b1;
                    tx_err      <= 1'b1;
                    tx_ready    <= 1'b1;
                    cnt         <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready, tx_done, tx_err;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    logic last_err;
    logic [1:0] last_code;

    always #5 clk = ~clk;

    // Open-drain bus: either side may pull a line low.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES      (20),
        .START_TIMEOUT_CYCLES(2000),
        .XFER_TIMEOUT_CYCLES (1000),
        .FILTER_LEN          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .err_code   (err_code),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Record every completion pulse with its status.
    always @(negedge clk) begin
        if (tx_done) begin
            done_cnt  <= done_cnt + 1;
            last_err  <= tx_err;
            last_code <= err_code;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    // Count cycles with the clock held low by the host.
    task automatic inhibit(output int hi, output logic last_d);
        hi = 0;
        last_d = 1'b0;
        while (ps2_clk_oe && hi < 200) begin
            hi++;
            last_d = ps2_data_oe;
            tick();
        end
        repeat (10) tick();
    endtask

    // Device generates nedges falling edges; samples each bit late in the low phase.
    task automatic dev_xfer(input int nedges, input bit ack_low, output logic [10:0] frame);
        frame = '0;
        frame[0] = ps2_data_in;
        for (int k = 1; k <= nedges; k++) begin
            if (k == 11 && ack_low) begin
                dev_data_low = 1'b1;
                repeat (5) tick();
            end
            dev_clk_low = 1'b1;
            repeat (25) tick();
            if (k <= 10) frame[k] = ps2_data_in;
            dev_clk_low = 1'b0;
            if (k == 11) begin
                repeat (5) tick();
                dev_data_low = 1'b0;
            end else begin
                repeat (25) tick();
            end
        end
    endtask

    task automatic wait_done(input int budget, input int base, output int cyc, output logic ok);
        cyc = 0;
        while (done_cnt == base && cyc < budget) begin
            tick();
            cyc++;
        end
        ok = (done_cnt != base);
    endtask

    initial begin
        int hi, cyc, base;
        logic last_d, ok;
        logic [10:0] frame;

        rst = 1'b0;
        tx_data = 8'h00;
        tx_start = 1'b0;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) tick();
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_err", tx_err, 1'b0);
        chk("rst_code", err_code, 2'd0);
        chk("rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("rst_data_oe", ps2_data_oe, 1'b0);
        rst = 1'b1;
        repeat (20) tick();

        // 1: enable reporting, device ACKs.
        base = done_cnt;
        send(8'hF4);
        chk("t1_busy", tx_ready, 1'b0);
        inhibit(hi, last_d);
        chk("t1_inhibit_len", hi, 20);
        chk("t1_start_in_last", last_d, 1'b1);
        dev_xfer(11, 1'b1, frame);
        wait_done(300, base, cyc, ok);
        chk("t1_done_seen", ok, 1'b1);
        chk("t1_frame", frame, {1'b1, 1'b0, 8'hF4, 1'b0});
        chk("t1_err", last_err, 1'b0);
        chk("t1_code", last_code, 2'd0);
        repeat (30) tick();
        chk("t1_ready", tx_ready, 1'b1);
        chk("t1_one_done", done_cnt - base, 1);

        // 2: reset command, device NACKs.
        base = done_cnt;
        send(8'hFF);
        inhibit(hi, last_d);
        dev_xfer(11, 1'b0, frame);
        wait_done(300, base, cyc, ok);
        chk("t2_done_seen", ok, 1'b1);
        chk("t2_frame", frame, {1'b1, 1'b1, 8'hFF, 1'b0});
        chk("t2_err", last_err, 1'b1);
        chk("t2_code", last_code, 2'd3);
        repeat (30) tick();
        chk("t2_code_held", err_code, 2'd3);

        // 3: device never clocks.
        base = done_cnt;
        send(8'hF4);
        hi = 0;
        while (ps2_clk_oe && hi < 200) begin
            hi++;
            tick();
        end
        wait_done(2100, base, cyc, ok);
        chk("t3_done_seen", ok, 1'b1);
        chk("t3_timeout_window", (cyc >= 1995 && cyc <= 2010), 1'b1);
        chk("t3_err", last_err, 1'b1);
        chk("t3_code", last_code, 2'd1);
        chk("t3_clk_oe", ps2_clk_oe, 1'b0);
        chk("t3_data_oe", ps2_data_oe, 1'b0);

        // 4: device stops after five edges.
        base = done_cnt;
        send(8'hF3);
        chk("t4_code_cleared", err_code, 2'd0);
        inhibit(hi, last_d);
        dev_xfer(5, 1'b1, frame);
        wait_done(1200, base, cyc, ok);
        chk("t4_done_seen", ok, 1'b1);
        chk("t4_timeout_window", (cyc + 250 >= 1000 && cyc + 250 <= 1030), 1'b1);
        chk("t4_err", last_err, 1'b1);
        chk("t4_code", last_code, 2'd2);
        chk("t4_clk_oe", ps2_clk_oe, 1'b0);
        chk("t4_data_oe", ps2_data_oe, 1'b0);

        // 5: asynchronous reset at the sixth edge, then a fresh 0x00 transfer.
        send(8'hF4);
        inhibit(hi, last_d);
        dev_xfer(5, 1'b1, frame);
        dev_clk_low = 1'b1;
        repeat (15) tick();
        rst = 1'b0;
        #1;
        chk("t5_async_clk_oe", ps2_clk_oe, 1'b0);
        chk("t5_async_data_oe", ps2_data_oe, 1'b0);
        chk("t5_async_ready", tx_ready, 1'b1);
        dev_clk_low = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (20) tick();
        base = done_cnt;
        send(8'h00);
        inhibit(hi, last_d);
        dev_xfer(11, 1'b1, frame);
        wait_done(300, base, cyc, ok);
        chk("t5_done_seen", ok, 1'b1);
        chk("t5_frame", frame, {1'b1, 1'b1, 8'h00, 1'b0});
        chk("t5_err", last_err, 1'b0);

        // 6: a request during SHIFT is ignored.
        base = done_cnt;
        send(8'hF3);
        inhibit(hi, last_d);
        fork
            dev_xfer(11, 1'b1, frame);
            begin
                repeat (150) tick();
                tx_data  = 8'hAA;
                tx_start = 1'b1;
                tick();
                tx_start = 1'b0;
            end
        join
        wait_done(300, base, cyc, ok);
        chk("t6_done_seen", ok, 1'b1);
        chk("t6_frame", frame, {1'b1, 1'b1, 8'hF3, 1'b0});
        chk("t6_err", last_err, 1'b0);
        repeat (300) tick();
        chk("t6_one_done", done_cnt - base, 1);
        chk("t6_idle_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
